// File: rtl/rv4028_bus_responder_if.sv
// RV4028 CPU bus signal bundle.
// The master side is the CPU; the slave side is the target responder.
interface rv4028_bus_responder_if;
  logic [31:0] addr;
  logic        rd_n;
  logic        wr_n;
  logic [1:0]  wrm_n;
  logic        mreq_n;
  logic        iorq_n;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;
  logic        wait_n;
  logic        int_n;

  modport master (
    output addr, rd_n, wr_n, wrm_n, mreq_n, iorq_n, data_in,
    input  data_out, data_oe, wait_n, int_n
  );

  modport slave (
    input  addr, rd_n, wr_n, wrm_n, mreq_n, iorq_n, data_in,
    output data_out, data_oe, wait_n, int_n
  );
endinterface

// File: rtl/rv4028_bus_responder.sv
// Target-side RV4028 bus responder: wait-state FSM, 16-bit word RAM in memory space and a
// compare timer with interrupt in IO space.
module rv4028_bus_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  IO_BASE     = 8'h00
) (
  input logic                      clk,
  input logic                      rst,
  rv4028_bus_responder_if.slave    bus
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WsInit = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        wait_n_q, wait_n_d;
  logic        data_oe_q, data_oe_d;
  logic [15:0] data_out_q, data_out_d;
  logic [15:0] count_q, count_d;
  logic [15:0] compare_q, compare_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        pending_q, pending_d;
  logic        ready_q;

  logic [15:0] ram [MEM_WORDS];

  logic          req_valid;
  logic          is_mem;
  logic          is_rd;
  logic          mem_hit;
  logic          io_hit;
  logic [AW-1:0] idx;
  logic [1:0]    reg_sel;
  logic [15:0]   io_rdata;
  logic [15:0]   acc_rdata;
  logic          access;
  logic [1:0]    mem_we;
  logic          unused_addr0;

  assign req_valid = (bus.mreq_n ^ bus.iorq_n) & (bus.rd_n ^ bus.wr_n);
  assign is_mem    = ~bus.mreq_n;
  assign is_rd     = ~bus.rd_n;
  assign mem_hit   = (bus.addr[31:AW+1] == '0);
  assign idx       = bus.addr[AW:1];
  assign io_hit    = (bus.addr[7:3] == IO_BASE[7:3]);
  assign reg_sel   = bus.addr[2:1];
  assign unused_addr0 = bus.addr[0];

  always_comb begin
    io_rdata = 16'h0000;
    unique case (reg_sel)
      2'd0: io_rdata = count_q;
      2'd1: io_rdata = compare_q;
      2'd2: io_rdata = {14'd0, ie_q, en_q};
      2'd3: io_rdata = {15'd0, pending_q};
      default: io_rdata = 16'h0000;
    endcase
  end

  assign acc_rdata = is_mem ? (mem_hit ? ram[idx] : 16'hFFFF)
                            : (io_hit  ? io_rdata : 16'hFFFF);

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    wait_n_d   = wait_n_q;
    data_oe_d  = data_oe_q;
    data_out_d = data_out_q;
    compare_d  = compare_q;
    en_d       = en_q;
    ie_d       = ie_q;
    pending_d  = pending_q;
    count_d    = en_q ? count_q + 16'd1 : count_q;
    access     = 1'b0;
    mem_we     = 2'b00;

    unique case (state_q)
      StIdle: begin
        // ready_q holds off accesses until the first edge after reset release
        if (req_valid && ready_q) begin
          if (WAIT_STATES == 0) begin
            access = 1'b1;
          end else begin
            state_d  = StWait;
            wait_n_d = 1'b0;
            wcnt_d   = WsInit;
          end
        end
      end
      StWait: begin
        if (!req_valid) begin
          state_d  = StIdle;
          wait_n_d = 1'b1;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          access   = 1'b1;
          wait_n_d = 1'b1;
        end
      end
      StDone: begin
        if (bus.rd_n && bus.wr_n) begin
          data_oe_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (access) begin
      state_d = StDone;
      if (is_rd) begin
        data_oe_d  = 1'b1;
        data_out_d = acc_rdata;
      end else if (is_mem) begin
        if (mem_hit) mem_we = ~bus.wrm_n;
      end else if (io_hit) begin
        unique case (reg_sel)
          2'd1: begin
            if (!bus.wrm_n[0]) compare_d[7:0]  = bus.data_in[7:0];
            if (!bus.wrm_n[1]) compare_d[15:8] = bus.data_in[15:8];
          end
          2'd2: begin
            if (!bus.wrm_n[0]) begin
              en_d = bus.data_in[0];
              ie_d = bus.data_in[1];
            end
          end
          2'd3: begin
            if (!bus.wrm_n[0] && bus.data_in[0]) pending_d = 1'b0;
          end
          default: ;
        endcase
      end
    end

    // Applied after the W1C so a same-edge match wins over the clear
    if (en_q && (count_q == compare_q)) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wcnt_q     <= 4'd0;
      wait_n_q   <= 1'b1;
      data_oe_q  <= 1'b0;
      data_out_q <= 16'h0000;
      count_q    <= 16'h0000;
      compare_q  <= 16'h0000;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      pending_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wait_n_q   <= wait_n_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      pending_q  <= pending_d;
      ready_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we[0]) ram[idx][7:0]  <= bus.data_in[7:0];
    if (mem_we[1]) ram[idx][15:8] <= bus.data_in[15:8];
  end

  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.wait_n   = wait_n_q;
  assign bus.int_n    = ~(pending_q & ie_q);

endmodule

// File: tb/tb_rv4028_bus_responder.sv
// Bench for rv4028_bus_responder: two instances (1 and 3 wait states) share one stimulus driver.
module tb_rv4028_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  int   cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        sel = 1'b0;
  logic [31:0] t_addr = '0;
  logic        t_rd_n = 1'b1, t_wr_n = 1'b1, t_mreq_n = 1'b1, t_iorq_n = 1'b1;
  logic [1:0]  t_wrm_n = 2'b11;
  logic [15:0] t_din = '0;

  rv4028_bus_responder_if b1 ();
  rv4028_bus_responder_if b3 ();

  assign b1.addr    = t_addr;
  assign b1.data_in = t_din;
  assign b1.wrm_n   = t_wrm_n;
  assign b1.rd_n    = sel ? 1'b1 : t_rd_n;
  assign b1.wr_n    = sel ? 1'b1 : t_wr_n;
  assign b1.mreq_n  = sel ? 1'b1 : t_mreq_n;
  assign b1.iorq_n  = sel ? 1'b1 : t_iorq_n;
  assign b3.addr    = t_addr;
  assign b3.data_in = t_din;
  assign b3.wrm_n   = t_wrm_n;
  assign b3.rd_n    = sel ? t_rd_n : 1'b1;
  assign b3.wr_n    = sel ? t_wr_n : 1'b1;
  assign b3.mreq_n  = sel ? t_mreq_n : 1'b1;
  assign b3.iorq_n  = sel ? t_iorq_n : 1'b1;

  logic        w_n, d_oe, i_n;
  logic [15:0] d_out;
  assign w_n   = sel ? b3.wait_n   : b1.wait_n;
  assign d_oe  = sel ? b3.data_oe  : b1.data_oe;
  assign i_n   = sel ? b3.int_n    : b1.int_n;
  assign d_out = sel ? b3.data_out : b1.data_out;

  rv4028_bus_responder #(.MEM_WORDS(1024), .WAIT_STATES(1), .IO_BASE(8'h00)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1)
  );

  rv4028_bus_responder #(.MEM_WORDS(64), .WAIT_STATES(3), .IO_BASE(8'h00)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3)
  );

  typedef struct {
    logic        mem;
    logic        rd;
    logic [31:0] addr;
    logic [15:0] data;
    logic [1:0]  wrm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[21];

  int   perf_cyc;
  logic perf_int_n, pre_int_n;

  logic [15:0] model [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    t_rd_n = 1'b1; t_wr_n = 1'b1; t_mreq_n = 1'b1; t_iorq_n = 1'b1; t_wrm_n = 2'b11;
  endtask

  // Called at a negedge with the responder idle; returns at a negedge with the bus released.
  task automatic do_access(input logic mem, input logic rd, input logic [31:0] a,
                           input logic [15:0] d, input logic [1:0] m, input logic chk_rd,
                           input logic [15:0] exp, output logic [15:0] rdata);
    int   waits = 0;
    logic done  = 1'b0;
    logic last_int;
    int   exp_ws = sel ? 3 : 1;
    t_addr = a; t_din = d; t_wrm_n = m;
    t_mreq_n = ~mem; t_iorq_n = mem; t_rd_n = ~rd; t_wr_n = rd;
    last_int = i_n;
    rdata = 16'h0000;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (w_n === 1'b0) waits++;
      else if (waits > 0) begin
        done = 1'b1; perf_cyc = cyc; perf_int_n = i_n; pre_int_n = last_int;
      end
      last_int = i_n;
    end
    chk("access_done", {31'd0, done}, 32'd1);
    chk("wait_cycles", waits, exp_ws);
    if (rd) begin
      chk("oe_on_read", {31'd0, d_oe}, 32'd1);
      rdata = d_out;
      if (chk_rd) chk("read_data", {16'd0, d_out}, {16'd0, exp});
      @(negedge clk);
      chk("oe_hold", {31'd0, d_oe}, 32'd1);
      if (chk_rd) chk("read_hold", {16'd0, d_out}, {16'd0, exp});
    end else begin
      chk("oe_on_write", {31'd0, d_oe}, 32'd0);
    end
    idle();
    @(negedge clk);
    chk("oe_release", {31'd0, d_oe}, 32'd0);
    chk("wait_idle", {31'd0, w_n}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd_v;
    int          en_cyc;
    vecs[0]  = '{1'b1, 1'b0, 32'h20,        16'hBEEF, 2'b00, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 32'h20,        16'h0000, 2'b11, 16'hBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h20,        16'h1234, 2'b10, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 32'h20,        16'h0000, 2'b11, 16'hBE34};
    vecs[4]  = '{1'b1, 1'b0, 32'h20,        16'h5555, 2'b11, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 32'h21,        16'h0000, 2'b11, 16'hBE34};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,         16'hA5A5, 2'b00, 16'h0000};
    vecs[7]  = '{1'b1, 1'b1, 32'h8000_0000, 16'h0000, 2'b11, 16'hFFFF};
    vecs[8]  = '{1'b1, 1'b0, 32'h8000_0000, 16'h1111, 2'b00, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 32'h0,         16'h0000, 2'b11, 16'hA5A5};
    vecs[10] = '{1'b0, 1'b1, 32'h40,        16'h0000, 2'b11, 16'hFFFF};
    vecs[11] = '{1'b0, 1'b0, 32'h02,        16'h1234, 2'b00, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 32'h02,        16'h0000, 2'b11, 16'h1234};
    vecs[13] = '{1'b0, 1'b0, 32'h04,        16'hFFFC, 2'b00, 16'h0000};
    vecs[14] = '{1'b0, 1'b1, 32'h04,        16'h0000, 2'b11, 16'h0000};
    vecs[15] = '{1'b0, 1'b1, 32'h06,        16'h0000, 2'b11, 16'h0000};
    vecs[16] = '{1'b0, 1'b1, 32'h00,        16'h0000, 2'b11, 16'h0000};
    vecs[17] = '{1'b0, 1'b0, 32'h42,        16'h7777, 2'b00, 16'h0000};
    vecs[18] = '{1'b0, 1'b1, 32'h02,        16'h0000, 2'b11, 16'h1234};
    vecs[19] = '{1'b0, 1'b0, 32'h02,        16'hAB00, 2'b01, 16'h0000};
    vecs[20] = '{1'b0, 1'b1, 32'h02,        16'h0000, 2'b11, 16'hAB34};

    // Reset held while strobes toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      t_addr = $urandom; t_din = $urandom; t_wrm_n = 2'($urandom);
      t_rd_n = 1'($urandom); t_wr_n = 1'($urandom);
      t_mreq_n = 1'($urandom); t_iorq_n = 1'($urandom);
      #1;
      chk("rst_wait_n", {31'd0, w_n}, 32'd1);
      chk("rst_int_n", {31'd0, i_n}, 32'd1);
      chk("rst_data_oe", {31'd0, d_oe}, 32'd0);
      chk("rst_data_out", {16'd0, d_out}, 32'd0);
    end
    idle();
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_wait_n", {31'd0, w_n}, 32'd1);
      chk("post_rst_oe", {31'd0, d_oe}, 32'd0);
    end

    // Directed vectors
    for (int i = 0; i < 21; i++)
      do_access(vecs[i].mem, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].wrm,
                vecs[i].rd, vecs[i].exp, rd_v);

    // Protocol errors: both strobes low, both spaces low
    t_addr = 32'h0; t_din = 16'hDEAD; t_wrm_n = 2'b00;
    t_mreq_n = 1'b0; t_rd_n = 1'b0; t_wr_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("proterr_rw_wait", {31'd0, w_n}, 32'd1);
      chk("proterr_rw_oe", {31'd0, d_oe}, 32'd0);
    end
    t_wr_n = 1'b1; t_iorq_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("proterr_sp_wait", {31'd0, w_n}, 32'd1);
      chk("proterr_sp_oe", {31'd0, d_oe}, 32'd0);
    end
    idle();
    @(negedge clk);
    do_access(1'b1, 1'b1, 32'h0, 16'h0, 2'b11, 1'b1, 16'hA5A5, rd_v);

    // Timer: COMPARE=5, then enable with ie
    do_access(1'b0, 1'b0, 32'h02, 16'h0005, 2'b00, 1'b0, 16'h0, rd_v);
    do_access(1'b0, 1'b0, 32'h04, 16'h0003, 2'b00, 1'b0, 16'h0, rd_v);
    en_cyc = perf_cyc;
    chk("int_after_ctrl", {31'd0, perf_int_n}, 32'd1);
    for (int i = 0; i < 20 && cyc != en_cyc + 5; i++) @(negedge clk);
    chk("int_edge5", {31'd0, i_n}, 32'd1);
    @(negedge clk);
    chk("int_edge6", {31'd0, i_n}, 32'd0);
    do_access(1'b0, 1'b1, 32'h06, 16'h0, 2'b11, 1'b1, 16'h0001, rd_v);
    do_access(1'b0, 1'b0, 32'h06, 16'h0001, 2'b00, 1'b0, 16'h0, rd_v);
    chk("w1c_int_before", {31'd0, pre_int_n}, 32'd0);
    chk("w1c_int_after", {31'd0, perf_int_n}, 32'd1);
    // ie=0 masks int_n while pending still latches
    do_access(1'b0, 1'b0, 32'h04, 16'h0001, 2'b00, 1'b0, 16'h0, rd_v);
    do_access(1'b0, 1'b1, 32'h00, 16'h0, 2'b11, 1'b0, 16'h0, rd_v);
    chk("count_value", {16'd0, rd_v}, {16'd0, 16'(perf_cyc - en_cyc - 1)});
    do_access(1'b0, 1'b0, 32'h02, rd_v + 16'd30, 2'b00, 1'b0, 16'h0, rd_v);
    repeat (40) @(negedge clk);
    chk("masked_int", {31'd0, i_n}, 32'd1);
    do_access(1'b0, 1'b1, 32'h06, 16'h0, 2'b11, 1'b1, 16'h0001, rd_v);
    do_access(1'b0, 1'b0, 32'h04, 16'h0003, 2'b00, 1'b0, 16'h0, rd_v);
    chk("unmask_int", {31'd0, perf_int_n}, 32'd0);
    do_access(1'b0, 1'b0, 32'h04, 16'h0001, 2'b00, 1'b0, 16'h0, rd_v);
    chk("remask_int", {31'd0, perf_int_n}, 32'd1);

    // Aborts on the 3-wait-state instance
    sel = 1'b1;
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h10, 16'hCAFE, 2'b00, 1'b0, 16'h0, rd_v);
    do_access(1'b1, 1'b1, 32'h10, 16'h0, 2'b11, 1'b1, 16'hCAFE, rd_v);
    for (int k = 0; k < 2; k++) begin
      t_addr = 32'h10; t_din = 16'hDEAD; t_wrm_n = 2'b00; t_mreq_n = 1'b0;
      if (k == 0) t_rd_n = 1'b0; else t_wr_n = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("abort_oe_wait", {31'd0, d_oe}, 32'd0);
      end
      chk("abort_in_wait", {31'd0, w_n}, 32'd0);
      idle();
      repeat (3) begin
        @(negedge clk);
        chk("abort_wait_n", {31'd0, w_n}, 32'd1);
        chk("abort_oe", {31'd0, d_oe}, 32'd0);
      end
    end
    do_access(1'b1, 1'b1, 32'h10, 16'h0, 2'b11, 1'b1, 16'hCAFE, rd_v);
    t_addr = 32'h10; t_din = 16'hBAD1; t_wrm_n = 2'b00; t_mreq_n = 1'b0; t_wr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_wait_low", {31'd0, w_n}, 32'd0);
    rst3 = 1'b1;
    #1;
    chk("rst_mid_wait_n", {31'd0, w_n}, 32'd1);
    chk("rst_mid_oe", {31'd0, d_oe}, 32'd0);
    idle();
    @(negedge clk);
    rst3 = 1'b0;
    @(negedge clk);
    do_access(1'b1, 1'b1, 32'h10, 16'h0, 2'b11, 1'b1, 16'hCAFE, rd_v);

    // Randomized traffic against a word-array model
    sel = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 64; w++) begin
      model[w] = 16'($urandom);
      do_access(1'b1, 1'b0, 32'(w * 2), model[w], 2'b00, 1'b0, 16'h0, rd_v);
    end
    for (int n = 0; n < 120; n++) begin
      logic [31:0] a;
      logic [15:0] d;
      logic [1:0]  m;
      logic        rd, oor;
      int          w;
      w   = $urandom_range(63);
      oor = ($urandom_range(7) == 0);
      a   = oor ? (32'h0001_0000 | 32'($urandom_range(65535)))
                : (32'(w * 2) | 32'($urandom_range(1)));
      d   = 16'($urandom);
      m   = 2'($urandom);
      rd  = 1'($urandom);
      if (rd) begin
        do_access(1'b1, 1'b1, a, 16'h0, 2'b11, 1'b1, oor ? 16'hFFFF : model[w], rd_v);
      end else begin
        do_access(1'b1, 1'b0, a, d, m, 1'b0, 16'h0, rd_v);
        if (!oor) begin
          if (!m[0]) model[w][7:0]  = d[7:0];
          if (!m[1]) model[w][15:8] = d[15:8];
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
